// File: rtl/rv32i_types.sv
// Shared RV32 types for the execute stage: M-extension funct3 codes and the
// multiply/divide unit state encoding.
package rv32i_types;

  localparam int MULDIV_ITERS = 32;

  typedef enum logic [2:0] {
    MEX_MUL    = 3'b000,
    MEX_MULH   = 3'b001,
    MEX_MULHSU = 3'b010,
    MEX_MULHU  = 3'b011,
    MEX_DIV    = 3'b100,
    MEX_DIVU   = 3'b101,
    MEX_REM    = 3'b110,
    MEX_REMU   = 3'b111
  } mex_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } muldiv_state_t;

endpackage

// File: rtl/rv32m_div_core.sv
// Restoring radix-2 divider step on unsigned magnitudes: one quotient bit per
// enabled cycle, remainder/quotient/divisor held locally.
module rv32m_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] dsr;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Bit XLEN of diff is the borrow: set means the trial subtraction failed.
  always_comb begin
    shifted = {remainder, quotient[XLEN-1]};
    diff    = shifted - {1'b0, dsr};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dsr       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (load) begin
      dsr       <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (step) begin
      remainder <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      quotient  <= {quotient[XLEN-2:0], ~diff[XLEN]};
    end
  end

endmodule

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit (IDLE -> CALC -> FIX). Defining
// MULDIV_FAST_MUL_EN routes multiplies through a single-cycle product instead.
module rv32m_muldiv
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = MULDIV_ITERS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  mex_funct3_t     funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(ITERS);

  muldiv_state_t     state;
  muldiv_state_t     state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              fix_phase;
  mex_funct3_t       op;
  logic [XLEN-1:0]   a_raw;
  logic [XLEN-1:0]   b_raw;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              neg_lo;
  logic              neg_hi;
  logic              special;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   fix_res;

  logic              in_is_div;
  logic              in_sa;
  logic              in_sb;
  logic              in_a_neg;
  logic              in_b_neg;
  logic              in_special;
  logic              in_fast;
  logic [XLEN-1:0]   in_a_mag;
  logic [XLEN-1:0]   in_b_mag;
  logic              launch;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_val;

  function automatic logic signed [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? -$signed(v) : $signed(v);
  endfunction

  function automatic logic signed [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -$signed(v) : $signed(v);
  endfunction

  // Operand decode on the issuing cycle
  always_comb begin
    in_is_div  = (funct3 == MEX_DIV) || (funct3 == MEX_DIVU) ||
                 (funct3 == MEX_REM) || (funct3 == MEX_REMU);
    in_sa      = (funct3 == MEX_MUL) || (funct3 == MEX_MULH) || (funct3 == MEX_MULHSU) ||
                 (funct3 == MEX_DIV) || (funct3 == MEX_REM);
    in_sb      = (funct3 == MEX_MUL) || (funct3 == MEX_MULH) ||
                 (funct3 == MEX_DIV) || (funct3 == MEX_REM);
    in_a_neg   = in_sa & rs1_data[XLEN-1];
    in_b_neg   = in_sb & rs2_data[XLEN-1];
    in_a_mag   = neg_if(rs1_data, in_a_neg);
    in_b_mag   = neg_if(rs2_data, in_b_neg);
    in_special = in_is_div &&
                 ((rs2_data == '0) ||
                  (in_sa && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1)));
`ifdef MULDIV_FAST_MUL_EN
    in_fast    = !in_is_div;
`else
    in_fast    = 1'b0;
`endif
    launch     = (state == IDLE) && start && !flush;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (in_special || in_fast) ? FIX : CALC;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     if (fix_phase) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign busy = (state != IDLE);

  rv32m_div_core #(
    .XLEN(XLEN)
  ) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .load     (launch),
    .step     (state == CALC),
    .dividend (in_a_mag),
    .divisor  (in_b_mag),
    .quotient (quo),
    .remainder(rem)
  );

  // Shift-add multiply: high half accumulates, multiplier drains out of the low half
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc[XLEN-1:1]};
  end

  // Sign correction and result-half selection
  always_comb begin
    fix_val = '0;
`ifdef MULDIV_FAST_MUL_EN
    prod    = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`else
    prod    = acc;
`endif
    prod    = neg_if_wide(prod, neg_lo);
    case (op)
      MEX_MUL:                        fix_val = prod[XLEN-1:0];
      MEX_MULH, MEX_MULHSU, MEX_MULHU: fix_val = prod[2*XLEN-1:XLEN];
      MEX_DIV, MEX_DIVU:
        if (special) fix_val = (b_raw == '0) ? '1 : {1'b1, {(XLEN-1){1'b0}}};
        else         fix_val = neg_if(quo, neg_lo);
      MEX_REM, MEX_REMU:
        if (special) fix_val = (b_raw == '0) ? a_raw : '0;
        else         fix_val = neg_if(rem, neg_hi);
      default:                        fix_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      fix_phase <= 1'b0;
      op        <= MEX_MUL;
      a_raw     <= '0;
      b_raw     <= '0;
      a_mag     <= '0;
      b_mag     <= '0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      special   <= 1'b0;
      acc       <= '0;
      fix_res   <= '0;
      result    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        fix_phase <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            op        <= funct3;
            a_raw     <= rs1_data;
            b_raw     <= rs2_data;
            a_mag     <= in_a_mag;
            b_mag     <= in_b_mag;
            neg_lo    <= in_a_neg ^ in_b_neg;
            neg_hi    <= in_a_neg;
            special   <= in_special;
            acc       <= {{XLEN{1'b0}}, in_b_mag};
            cnt       <= CNT_W'(ITERS - 1);
            fix_phase <= 1'b0;
          end
          CALC: begin
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
            acc <= mul_next;
          end
          // FIX spends one cycle registering the corrected value, one presenting it
          FIX: if (!fix_phase) begin
            fix_res   <= fix_val;
            fix_phase <= 1'b1;
          end else begin
            result    <= fix_res;
            done      <= 1'b1;
            fix_phase <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Randomized and directed bench for rv32m_muldiv against a plain-arithmetic
// RV32M reference model.
module tb_rv32m_muldiv;
  import rv32i_types::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  mex_funct3_t funct3 = MEX_MUL;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          passed = 0;
  int          total = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    mex_funct3_t f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  rv32m_muldiv dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .flush   (flush),
    .funct3  (funct3),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input mex_funct3_t f, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'b0, a});
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    case (f)
      MEX_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
      MEX_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      MEX_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      MEX_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      MEX_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      MEX_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      MEX_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      default:  return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input mex_funct3_t f, input logic [31:0] a, input logic [31:0] b);
    bit is_div;
    is_div = (f == MEX_DIV) || (f == MEX_DIVU) || (f == MEX_REM) || (f == MEX_REMU);
    if (is_div && b == 32'h0) return 2;
    if ((f == MEX_DIV || f == MEX_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    if (!is_div) return MUL_LAT;
    return 34;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(5, 0))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(15, 0));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op and waits (bounded) for done; clean=0 on any protocol violation
  task automatic run_op(input mex_funct3_t f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit clean);
    clean = 1'b1;
    lat   = -1;
    @(negedge clk);
    funct3 = f; rs1_data = a; rs2_data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy !== 1'b1 || done !== 1'b0) clean = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1 && busy !== 1'b0) clean = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1) clean = 1'b0;
    end
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
    total++; if (result !== 32'h0) $display("FAIL reset_result got=%h exp=00000000", result); else passed++;
    @(negedge clk);
    rst = 1'b1;
    last_res = 32'h0;
  endtask

  task automatic test_directed();
    vec_t        v[$];
    logic [31:0] res;
    int          lat;
    bit          clean;
    v.push_back('{MEX_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT});
    v.push_back('{MEX_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT});
    v.push_back('{MEX_MULHSU, 32'h8000_0000,  32'h8000_0000, 32'hC000_0000, MUL_LAT});
    v.push_back('{MEX_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT});
    v.push_back('{MEX_DIV,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFD, 34});
    v.push_back('{MEX_REM,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE, 34});
    v.push_back('{MEX_DIVU,   32'd20,         32'd6,         32'd3,         34});
    v.push_back('{MEX_REMU,   32'd20,         32'd6,         32'd2,         34});
    v.push_back('{MEX_DIV,    32'h1234_5678,  32'h0,         32'hFFFF_FFFF, 2});
    v.push_back('{MEX_REM,    32'h1234_5678,  32'h0,         32'h1234_5678, 2});
    v.push_back('{MEX_DIVU,   32'h1234_5678,  32'h0,         32'hFFFF_FFFF, 2});
    v.push_back('{MEX_REMU,   32'h1234_5678,  32'h0,         32'h1234_5678, 2});
    v.push_back('{MEX_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2});
    v.push_back('{MEX_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         2});
    v.push_back('{MEX_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         34});
    foreach (v[i]) begin
      run_op(v[i].f, v[i].a, v[i].b, res, lat, clean);
      total++;
      if (res !== v[i].exp)
        $display("FAIL dir_result[%0d] op=%0d got=%h exp=%h", i, int'(v[i].f), res, v[i].exp);
      else passed++;
      total++;
      if (lat != v[i].lat)
        $display("FAIL dir_latency[%0d] op=%0d got=%0d exp=%0d", i, int'(v[i].f), lat, v[i].lat);
      else passed++;
      total++;
      if (!clean) $display("FAIL dir_protocol[%0d] busy/done sequence wrong", i); else passed++;
      last_res = v[i].exp;
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || result !== last_res)
      $display("FAIL done_pulse_hold done=%b result=%h exp done=0 result=%h", done, result, last_res);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp;
    mex_funct3_t f;
    int          lat;
    bit          clean, all_clean;
    all_clean = 1'b1;
    for (int i = 0; i < 40; i++) begin
      f   = mex_funct3_t'(3'($urandom_range(7, 0)));
      a   = rand_opnd();
      b   = rand_opnd();
      exp = model(f, a, b);
      run_op(f, a, b, res, lat, clean);
      if (!clean) all_clean = 1'b0;
      total++;
      if (res !== exp)
        $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, int'(f), a, b, res, exp);
      else passed++;
      total++;
      if (lat != exp_lat(f, a, b))
        $display("FAIL rand_latency[%0d] op=%0d got=%0d exp=%0d", i, int'(f), lat, exp_lat(f, a, b));
      else passed++;
      last_res = exp;
    end
    total++;
    if (!all_clean) $display("FAIL rand_protocol busy/done sequence wrong"); else passed++;
  endtask

  task automatic test_flush();
    logic [31:0] a, b, res, exp;
    int          lat;
    bit          clean, saw_done;
    a = $urandom;
    b = $urandom | 32'h1;
    @(negedge clk);
    funct3 = MEX_DIV; rs1_data = a; rs2_data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL flush_busy got=%b exp=0", busy); else passed++;
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (saw_done) $display("FAIL flush_no_done got=1 exp=0"); else passed++;
    total++;
    if (result !== last_res) $display("FAIL flush_result_hold got=%h exp=%h", result, last_res);
    else passed++;
    a = $urandom;
    b = $urandom | 32'h1;
    exp = model(MEX_REMU, a, b);
    run_op(MEX_REMU, a, b, res, lat, clean);
    total++;
    if (res !== exp || lat != 34 || !clean)
      $display("FAIL flush_recover got=%h lat=%0d exp=%h lat=34", res, lat, exp);
    else passed++;
    last_res = exp;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    funct3 = MEX_DIVU; rs1_data = $urandom; rs2_data = $urandom | 32'h1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rstmid_done got=%b exp=0", done); else passed++;
    total++; if (result !== 32'h0) $display("FAIL rstmid_result got=%h exp=00000000", result); else passed++;
    @(negedge clk);
    rst = 1'b1;
    last_res = 32'h0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, exp1, exp2;
    int          n1, n2;
    a1 = $urandom; b1 = 32'($urandom_range(1000, 3));
    a2 = $urandom; b2 = 32'($urandom_range(99, 2));
    exp1 = model(MEX_DIVU, a1, b1);
    exp2 = model(MEX_REM, a2, b2);
    @(negedge clk);
    funct3 = MEX_DIVU; rs1_data = a1; rs2_data = b1; start = 1'b1;
    @(posedge clk); #1;
    // start stays high with the second op's operands for the whole first op
    funct3 = MEX_REM; rs1_data = a2; rs2_data = b2;
    n1 = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n1 = n;
        break;
      end
    end
    total++;
    if (result !== exp1) $display("FAIL b2b_first_result got=%h exp=%h", result, exp1); else passed++;
    total++;
    if (n1 != 34) $display("FAIL b2b_first_latency got=%0d exp=34", n1); else passed++;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL b2b_second_accept busy got=%b exp=1", busy); else passed++;
    n2 = -1;
    for (int n = 2; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n2 = n;
        break;
      end
    end
    total++;
    if (result !== exp2) $display("FAIL b2b_second_result got=%h exp=%h", result, exp2); else passed++;
    total++;
    if (n2 != 35) $display("FAIL b2b_second_latency got=%0d exp=35", n2); else passed++;
    last_res = exp2;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
